state_change2: RTL and testbench



---
 rtl/state_change_pkg.sv | 7 +
 rtl/state_dwell_timer.sv | 20 ++
 rtl/state_change2.sv | 60 ++++++
 tb/tb_state_change2.sv | 118 +++++++++++
 4 files changed

// File: rtl/state_change_pkg.sv
// state_change_pkg: shared defaults and the state type for FSM state registers.
package state_change_pkg;
  localparam int STATE_W_DEF = 3;
  localparam int RESET_STATE_DEF = 0;
  localparam int CNT_W_DEF = 16;
  typedef logic [STATE_W_DEF-1:0] state_t;
endpackage

// File: rtl/state_dwell_timer.sv
// state_dwell_timer: saturating dwell counter with clear and timeout compare (TIMEOUT=0 disables).
module state_dwell_timer import state_change_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] TO = TIMEOUT[CNT_W-1:0];
  if (TIMEOUT < 0 || (CNT_W < 31 && TIMEOUT >= (1 << CNT_W))) begin : g_bad_timeout
    $error("state_dwell_timer: TIMEOUT exceeds dwell counter range");
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (&cnt ? cnt : cnt + 1'b1);
  assign timeout = (TIMEOUT != 0) && (cnt >= TO);
endmodule

// File: rtl/state_change2.sv
// state_change2: FSM state register with force-load, change pulse, dwell timer.
// Define STATE_CHANGE_HIST_EN to add a state history shift register.
module state_change2 import state_change_pkg::*; #(
  parameter int STATE_W = STATE_W_DEF,
  parameter int RESET_STATE = RESET_STATE_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = 0,
  parameter int HIST_DEPTH = 4,
  localparam int HC_W = $clog2(HIST_DEPTH + 1),
  localparam int HIST_W = HIST_DEPTH * STATE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [STATE_W-1:0] state_next,
  input  logic               force_valid,
  input  logic [STATE_W-1:0] force_state,
  output logic [STATE_W-1:0] state_reg,
  output logic [STATE_W-1:0] state_prev,
  output logic               changed,
  output logic [CNT_W-1:0]   dwell_cnt,
  output logic               timeout,
  output logic [HIST_W-1:0]  hist_flat,
  output logic [HC_W-1:0]    hist_cnt
);
  localparam logic [STATE_W-1:0] RST = RESET_STATE[STATE_W-1:0];
  logic [STATE_W-1:0] cand;
  logic chg;
  assign cand = force_valid ? force_state : state_next;
  assign chg = (force_valid || en) && (cand != state_reg);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_reg <= RST;
      state_prev <= RST;
      changed <= 1'b0;
    end else begin
      changed <= chg;
      if (chg) begin
        state_reg <= cand;
        state_prev <= state_reg;
      end
    end
  state_dwell_timer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(chg), .cnt(dwell_cnt), .timeout(timeout)
  );
`ifdef STATE_CHANGE_HIST_EN
  // Entry 0 is the newest departed state, so it mirrors state_prev.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist_flat <= '0;
      hist_cnt <= '0;
    end else if (chg) begin
      hist_flat <= (hist_flat << STATE_W) | HIST_W'(state_reg);
      if (hist_cnt != HC_W'(HIST_DEPTH)) hist_cnt <= hist_cnt + 1'b1;
    end
`else
  assign hist_flat = '0;
  assign hist_cnt = '0;
`endif
endmodule

// File: tb/tb_state_change2.sv
// tb_state_change2: directed self-checking bench for state_change2.
module tb_state_change2;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, force_valid = 1'b0;
  logic [2:0] state_next = '0, force_state = '0, state_reg, state_prev;
  logic changed, timeout;
  logic [3:0] dwell_cnt;
  logic [11:0] hist_flat;
  logic [2:0] hist_cnt;
  int total = 0, passed = 0;

  state_change2 #(.STATE_W(3), .RESET_STATE(5), .CNT_W(4), .TIMEOUT(8), .HIST_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .state_next(state_next),
    .force_valid(force_valid), .force_state(force_state),
    .state_reg(state_reg), .state_prev(state_prev), .changed(changed),
    .dwell_cnt(dwell_cnt), .timeout(timeout), .hist_flat(hist_flat), .hist_cnt(hist_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] seq [6];
    logic [2:0] hexp [4];
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
`ifdef STATE_CHANGE_HIST_EN
    hexp = '{3'd4, 3'd3, 3'd2, 3'd1};
`else
    hexp = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
    tick();
    chk("rst_state", state_reg, 5);
    chk("rst_prev", state_prev, 5);
    chk("rst_changed", changed, 0);
    chk("rst_dwell", dwell_cnt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_hist", hist_flat, 0);
    chk("rst_hcnt", hist_cnt, 0);
    rst_n = 1'b1;
    en = 1'b1;
    state_next = 3'd0;
    tick();
    chk("chg0_state", state_reg, 0);
    chk("chg0_prev", state_prev, 5);
    chk("chg0_changed", changed, 1);
    state_next = 3'd3;
    tick();
    chk("chg3_state", state_reg, 3);
    chk("chg3_prev", state_prev, 0);
    chk("chg3_changed", changed, 1);
    chk("chg3_dwell", dwell_cnt, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("reload_changed", changed, 0);
      chk("reload_dwell", dwell_cnt, i);
      chk("reload_timeout", timeout, (i >= 8) ? 1 : 0);
    end
    chk("reload_state", state_reg, 3);
    en = 1'b0;
    for (int i = 11; i <= 18; i++) begin
      tick();
      chk("sat_dwell", dwell_cnt, (i > 15) ? 15 : i);
    end
    chk("sat_timeout", timeout, 1);
    force_valid = 1'b1;
    force_state = 3'd6;
    en = 1'b1;
    state_next = 3'd1;
    tick();
    chk("force_state", state_reg, 6);
    chk("force_prev", state_prev, 3);
    chk("force_changed", changed, 1);
    chk("force_dwell", dwell_cnt, 0);
    chk("force_timeout", timeout, 0);
    force_valid = 1'b0;
    en = 1'b0;
    tick();
    chk("idle_changed", changed, 0);
    chk("idle_dwell", dwell_cnt, 1);
    en = 1'b1;
    state_next = 3'd2;
    tick();
    chk("pre_rst_state", state_reg, 2);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state_reg, 5);
    chk("async_rst_dwell", dwell_cnt, 0);
    chk("async_rst_changed", changed, 0);
    tick();
    chk("held_rst_state", state_reg, 5);
    rst_n = 1'b1;
    en = 1'b1;
    foreach (seq[i]) begin
      state_next = seq[i];
      tick();
      chk("hist_seq_changed", changed, 1);
    end
    chk("hist_state", state_reg, 5);
    chk("hist_prev", state_prev, 4);
    for (int i = 0; i < 4; i++) chk("hist_entry", hist_flat[i*3 +: 3], hexp[i]);
`ifdef STATE_CHANGE_HIST_EN
    chk("hist_cnt", hist_cnt, 4);
`else
    chk("hist_cnt", hist_cnt, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
